// File: rtl/alu_control_muldiv_pkg.sv
// Shared encodings for the EX-stage ALU control / HI-LO mul-div block:
// ALUOp classes, funct codes, ALU operation selects and the sequencer states.
package alu_ctrl_pkg;

  typedef enum logic [2:0] {
    AOP_ADD   = 3'b000,
    AOP_SUB   = 3'b001,
    AOP_RTYPE = 3'b010,
    AOP_AND   = 3'b011,
    AOP_OR    = 3'b100,
    AOP_XOR   = 3'b101,
    AOP_SLT   = 3'b110,
    AOP_LUI   = 3'b111
  } aluop_e;

  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_SLLV  = 6'h04;
  localparam logic [5:0] F_SRLV  = 6'h06;
  localparam logic [5:0] F_SRAV  = 6'h07;
  localparam logic [5:0] F_JALR  = 6'h09;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;

  typedef enum logic [4:0] {
    ALU_ADD     = 5'd0,
    ALU_ADDU    = 5'd1,
    ALU_SUB     = 5'd2,
    ALU_SUBU    = 5'd3,
    ALU_AND     = 5'd4,
    ALU_OR      = 5'd5,
    ALU_XOR     = 5'd6,
    ALU_NOR     = 5'd7,
    ALU_SLT     = 5'd8,
    ALU_SLTU    = 5'd9,
    ALU_SLL     = 5'd10,
    ALU_SRL     = 5'd11,
    ALU_SRA     = 5'd12,
    ALU_SLLV    = 5'd13,
    ALU_SRLV    = 5'd14,
    ALU_SRAV    = 5'd15,
    ALU_LUI     = 5'd16,
    ALU_JALR    = 5'd17,
    ALU_PASS_HI = 5'd18,
    ALU_PASS_LO = 5'd19,
    ALU_NOP     = 5'd31
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

endpackage

// File: rtl/alu_control_muldiv_if.sv
// EX-stage bundle between the pipeline and the ALU control / mul-div block.
interface alu_control_muldiv_if #(
  parameter int NBITS_FUNCT = 6,
  parameter int NBITS_ALUOP = 3,
  parameter int NBITS_CTRL  = 5,
  parameter int NBITS_DATA  = 32
);
  logic                   i_Valid;
  logic [NBITS_FUNCT-1:0] i_Instruction;
  logic [NBITS_ALUOP-1:0] i_ALUOp;
  logic [NBITS_DATA-1:0]  i_OpA;
  logic [NBITS_DATA-1:0]  i_OpB;
  logic [NBITS_CTRL-1:0]  o_ALUCtrl;
  logic                   o_Stall;
  logic [NBITS_DATA-1:0]  o_Hi;
  logic [NBITS_DATA-1:0]  o_Lo;
  logic                   o_MdDone;

  modport master (
    output i_Valid, i_Instruction, i_ALUOp, i_OpA, i_OpB,
    input  o_ALUCtrl, o_Stall, o_Hi, o_Lo, o_MdDone
  );

  modport slave (
    input  i_Valid, i_Instruction, i_ALUOp, i_OpA, i_OpB,
    output o_ALUCtrl, o_Stall, o_Hi, o_Lo, o_MdDone
  );
endinterface

// File: rtl/alu_control_muldiv_md_iter_core.sv
// One-step-per-cycle unsigned shift-add multiplier / restoring divider.
// Operates on magnitudes; sign handling lives in the caller.
module md_iter_core #(
  parameter int NBITS_DATA = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  step,
  input  logic                  is_div,
  input  logic [NBITS_DATA-1:0] a_in,
  input  logic [NBITS_DATA-1:0] b_in,
  output logic [NBITS_DATA-1:0] nxt_hi,
  output logic [NBITS_DATA-1:0] nxt_lo
);
  localparam int N = NBITS_DATA;

  // hi_r: partial product / remainder, lo_r: multiplier bits / dividend-quotient shift reg
  logic [N-1:0] hi_r, lo_r, m_r;
  logic         div_r;
  logic [N:0]   mul_sum, div_sh, div_df;

  always_comb begin
    mul_sum = {1'b0, hi_r} + (lo_r[0] ? {1'b0, m_r} : '0);
    div_sh  = {hi_r, lo_r[N-1]};
    div_df  = div_sh - {1'b0, m_r};
    if (div_r) begin
      if (!div_df[N]) begin
        nxt_hi = div_df[N-1:0];
        nxt_lo = {lo_r[N-2:0], 1'b1};
      end else begin
        nxt_hi = div_sh[N-1:0];
        nxt_lo = {lo_r[N-2:0], 1'b0};
      end
    end else begin
      nxt_hi = mul_sum[N:1];
      nxt_lo = {mul_sum[0], lo_r[N-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_r  <= '0;
      lo_r  <= '0;
      m_r   <= '0;
      div_r <= 1'b0;
    end else if (load) begin
      hi_r  <= '0;
      lo_r  <= a_in;
      m_r   <= b_in;
      div_r <= is_div;
    end else if (step) begin
      hi_r  <= nxt_hi;
      lo_r  <= nxt_lo;
    end
  end
endmodule

// File: rtl/alu_control_muldiv.sv
// EX-stage ALU control decoder plus architectural HI/LO with an iterative
// MULT/MULTU/DIV/DIVU sequencer that stalls the pipeline while it runs.
module alu_control_muldiv import alu_ctrl_pkg::*; #(
  parameter int NBITS_FUNCT = 6,
  parameter int NBITS_ALUOP = 3,
  parameter int NBITS_CTRL  = 5,
  parameter int NBITS_DATA  = 32
) (
  input logic                i_clk,
  input logic                i_reset,
  alu_control_muldiv_if.slave bus
);
  localparam int N  = NBITS_DATA;
  localparam int CW = $clog2(NBITS_DATA);

  logic [NBITS_FUNCT-1:0] funct;
  logic [NBITS_ALUOP-1:0] aluop;
  alu_ctrl_e              ctrl;
  logic                   is_rtype, is_md, md_signed, md_div, wr_hi, wr_lo;
  logic [N-1:0]           a_mag, b_mag, core_hi, core_lo, fix_hi, fix_lo;
  logic [2*N-1:0]         prod;
  logic                   a_neg, b_neg;

  md_state_e   state;
  logic [CW-1:0] cnt;
  logic        op_div, neg_a, neg_b, div_zero, mddone_r;
  logic [N-1:0] opa_r, hi_r, lo_r;

  assign funct = bus.i_Instruction;
  assign aluop = bus.i_ALUOp;

  always_comb begin
    ctrl = ALU_NOP;
    case (aluop)
      AOP_ADD:   ctrl = ALU_ADD;
      AOP_SUB:   ctrl = ALU_SUB;
      AOP_AND:   ctrl = ALU_AND;
      AOP_OR:    ctrl = ALU_OR;
      AOP_XOR:   ctrl = ALU_XOR;
      AOP_SLT:   ctrl = ALU_SLT;
      AOP_LUI:   ctrl = ALU_LUI;
      AOP_RTYPE: begin
        case (funct)
          F_ADD:   ctrl = ALU_ADD;
          F_ADDU:  ctrl = ALU_ADDU;
          F_SUB:   ctrl = ALU_SUB;
          F_SUBU:  ctrl = ALU_SUBU;
          F_AND:   ctrl = ALU_AND;
          F_OR:    ctrl = ALU_OR;
          F_XOR:   ctrl = ALU_XOR;
          F_NOR:   ctrl = ALU_NOR;
          F_SLT:   ctrl = ALU_SLT;
          F_SLTU:  ctrl = ALU_SLTU;
          F_SLL:   ctrl = ALU_SLL;
          F_SRL:   ctrl = ALU_SRL;
          F_SRA:   ctrl = ALU_SRA;
          F_SLLV:  ctrl = ALU_SLLV;
          F_SRLV:  ctrl = ALU_SRLV;
          F_SRAV:  ctrl = ALU_SRAV;
          F_JALR:  ctrl = ALU_JALR;
          F_MFHI:  ctrl = ALU_PASS_HI;
          F_MFLO:  ctrl = ALU_PASS_LO;
          default: ctrl = ALU_NOP;
        endcase
      end
      default:   ctrl = ALU_NOP;
    endcase
  end

  assign is_rtype  = bus.i_Valid && (aluop == AOP_RTYPE);
  assign is_md     = is_rtype && (funct inside {F_MULT, F_MULTU, F_DIV, F_DIVU});
  assign md_signed = (funct == F_MULT) || (funct == F_DIV);
  assign md_div    = (funct == F_DIV) || (funct == F_DIVU);
  // HI/LO moves retire in DONE as well, since HI/LO were already committed on entry
  assign wr_hi     = is_rtype && (funct == F_MTHI) && (state != ST_BUSY);
  assign wr_lo     = is_rtype && (funct == F_MTLO) && (state != ST_BUSY);

  assign a_neg = md_signed && bus.i_OpA[N-1];
  assign b_neg = md_signed && bus.i_OpB[N-1];
  assign a_mag = a_neg ? -bus.i_OpA : bus.i_OpA;
  assign b_mag = b_neg ? -bus.i_OpB : bus.i_OpB;

  md_iter_core #(.NBITS_DATA(N)) u_core (
    .clk    (i_clk),
    .reset  (i_reset),
    .load   (state == ST_IDLE && is_md),
    .step   (state == ST_BUSY),
    .is_div (md_div),
    .a_in   (a_mag),
    .b_in   (b_mag),
    .nxt_hi (core_hi),
    .nxt_lo (core_lo)
  );

  // Sign fix on the final step's result; remainder follows the dividend's sign
  always_comb begin
    prod   = {core_hi, core_lo};
    if (neg_a ^ neg_b) prod = -prod;
    fix_lo = (neg_a ^ neg_b) ? -core_lo : core_lo;
    fix_hi = neg_a ? -core_hi : core_hi;
    if (!op_div) begin
      {fix_hi, fix_lo} = prod;
    end else if (div_zero) begin
      fix_hi = opa_r;
      fix_lo = '1;
    end
  end

  // Start only from IDLE: the held MD op retires during DONE and never re-triggers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      op_div   <= 1'b0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      div_zero <= 1'b0;
      opa_r    <= '0;
      hi_r     <= '0;
      lo_r     <= '0;
      mddone_r <= 1'b0;
    end else begin
      mddone_r <= 1'b0;
      if (wr_hi) hi_r <= bus.i_OpA;
      if (wr_lo) lo_r <= bus.i_OpA;
      case (state)
        ST_IDLE: begin
          if (is_md) begin
            op_div   <= md_div;
            neg_a    <= a_neg;
            neg_b    <= b_neg;
            div_zero <= (bus.i_OpB == '0);
            opa_r    <= bus.i_OpA;
            cnt      <= CW'(N - 1);
            state    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (cnt == '0) begin
            hi_r     <= fix_hi;
            lo_r     <= fix_lo;
            mddone_r <= 1'b1;
            state    <= ST_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_ALUCtrl = NBITS_CTRL'(ctrl);
  assign bus.o_Stall   = (state == ST_BUSY) || (state == ST_IDLE && is_md);
  assign bus.o_Hi      = hi_r;
  assign bus.o_Lo      = lo_r;
  assign bus.o_MdDone  = mddone_r;
endmodule
